// File: rtl/kernel3_gmem_b_m_axi_wbeat_issuer_pkg.sv
// Shared types for the gmem_B W-channel beat issuer.
//   issuer_state_e : command FSM states (IDLE waits for a burst, SEND streams beats)
//   slice_occ_e    : occupancy of the 2-entry output slice
//   strb_width()   : byte-enable width for a given data width
package kernel3_gmem_b_m_axi_wbeat_issuer_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int LEN_WIDTH_DEF  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } issuer_state_e;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    ONE  = 2'd1,
    TWO  = 2'd2
  } slice_occ_e;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/kernel3_gmem_b_m_axi_wbeat_issuer_if.sv
// Bundle of the command, kernel beat stream and AXI W signals around the issuer.
//   master : issuer view (drives cmd_ready, in_ready, m_w*, burst_done)
//   slave  : environment view (drives cmd_*, in_*, m_wready)
interface kernel3_gmem_b_m_axi_wbeat_issuer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic [STRB_WIDTH-1:0] in_strb;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [STRB_WIDTH-1:0] m_wstrb;
  logic                  m_wlast;
  logic                  m_wvalid;
  logic                  m_wready;
  logic                  burst_done;

  modport master (
    input  cmd_len, cmd_valid, in_data, in_strb, in_valid, m_wready,
    output cmd_ready, in_ready, m_wdata, m_wstrb, m_wlast, m_wvalid, burst_done
  );

  modport slave (
    output cmd_len, cmd_valid, in_data, in_strb, in_valid, m_wready,
    input  cmd_ready, in_ready, m_wdata, m_wstrb, m_wlast, m_wvalid, burst_done
  );

endinterface

// File: rtl/kernel3_gmem_b_m_axi_wbeat_slice.sv
// Two-entry registered valid/ready slice. Full throughput with a registered
// s_ready: the second (skid) entry absorbs the beat arriving in the cycle
// the downstream stalls.
//   clk, reset        : clock, synchronous active-high reset
//   s_data/valid/ready: upstream side
//   m_data/valid/ready: downstream side (m_data held while m_valid & ~m_ready)
module kernel3_gmem_b_m_axi_wbeat_slice
  import kernel3_gmem_b_m_axi_wbeat_issuer_pkg::*;
#(
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  slice_occ_e       occ;
  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic             s_ready_q;
  logic             push;
  logic             pop;

  assign s_ready = s_ready_q;
  assign m_data  = head_q;
  assign m_valid = (occ != ZERO);
  assign push    = s_valid & s_ready_q;
  assign pop     = m_valid & m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      occ       <= ZERO;
      s_ready_q <= 1'b1;
      head_q    <= '0;
      skid_q    <= '0;
    end else begin
      case (occ)
        ZERO: begin
          if (push) begin
            head_q <= s_data;
            occ    <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_q <= s_data;
          end else if (push) begin
            // downstream stalled: park the new beat behind the head
            skid_q    <= s_data;
            occ       <= TWO;
            s_ready_q <= 1'b0;
          end else if (pop) begin
            occ <= ZERO;
          end
        end
        TWO: begin
          if (pop) begin
            head_q    <= skid_q;
            occ       <= ONE;
            s_ready_q <= 1'b1;
          end
        end
        default: begin
          occ       <= ZERO;
          s_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/kernel3_gmem_b_m_axi_wbeat_issuer.sv
// gmem_B AXI4 W-channel issuer: accepts a burst command (beats-1), pulls that
// many beats from the kernel stream and drives them on W, tagging the final
// beat with WLAST. burst_done pulses the cycle after a WLAST beat is accepted.
//   clk, reset : clock, synchronous active-high reset
//   bus.cmd_*  : burst command (cmd_len = beats-1)
//   bus.in_*   : kernel beat stream (data + byte strobes)
//   bus.m_w*   : AXI W channel, all outputs registered
//   bus.burst_done : per-burst completion pulse
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high, no beats accepted
// SEND  | streaming beats, beat_cnt = beats remaining after the current one
module kernel3_gmem_b_m_axi_wbeat_issuer
  import kernel3_gmem_b_m_axi_wbeat_issuer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input logic clk,
  input logic reset,
  kernel3_gmem_b_m_axi_wbeat_issuer_if.master bus
);

  localparam int STRB_WIDTH = strb_width(DATA_WIDTH);
  localparam int PW         = DATA_WIDTH + STRB_WIDTH + 1;

  issuer_state_e        state;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic                 cmd_ready_q;
  logic                 burst_done_q;
  logic                 s_ready;
  logic                 beat_push;
  logic                 beat_last;
  logic                 m_valid;
  logic [PW-1:0]        s_payload;
  logic [PW-1:0]        m_payload;

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.in_ready   = (state == SEND) & s_ready;
  assign bus.burst_done = burst_done_q;

  assign beat_push = bus.in_valid & bus.in_ready;
  // beat_cnt holds beats-1 remaining, so zero marks the final beat and the
  // counter never has to go below zero (no wrap at 2^LEN_WIDTH beats)
  assign beat_last = (beat_cnt == '0);
  assign s_payload = {bus.in_data, bus.in_strb, beat_last};

  kernel3_gmem_b_m_axi_wbeat_slice #(
    .WIDTH (PW)
  ) u_slice (
    .clk     (clk),
    .reset   (reset),
    .s_data  (s_payload),
    .s_valid (bus.in_valid & (state == SEND)),
    .s_ready (s_ready),
    .m_data  (m_payload),
    .m_valid (m_valid),
    .m_ready (bus.m_wready)
  );

  assign {bus.m_wdata, bus.m_wstrb, bus.m_wlast} = m_payload;
  assign bus.m_wvalid = m_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      cmd_ready_q  <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      burst_done_q <= m_valid & bus.m_wready & bus.m_wlast;
      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            state       <= SEND;
            beat_cnt    <= bus.cmd_len;
            cmd_ready_q <= 1'b0;
          end
        end
        SEND: begin
          if (beat_push) begin
            if (beat_last) begin
              state       <= IDLE;
              cmd_ready_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          cmd_ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
